// File: rtl/layer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// layer_ctrl_pkg
// Shared definitions for the neuron layer configuration master:
//   - Avalon-MM data/address width
//   - default slave map (base address of neuron 0, byte stride between slaves)
//   - FSM state encoding
//   - helper to build the nInputs field mask for a given field width
// -----------------------------------------------------------------------------
package layer_ctrl_pkg;

  localparam int AVM_DATA_W = 32;
  localparam int ERR_IDX_W  = 4;

  localparam logic [AVM_DATA_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam logic [AVM_DATA_W-1:0] DEFAULT_STRIDE    = 32'h0000_0010;

  // Explicit encodings keep the state values stable for anyone probing the
  // register in a waveform or older netlist-level tests.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Mask with the low 'width' bits set; bits above it are the ones a slave
  // must return as zero on readback.
  function automatic logic [AVM_DATA_W-1:0] field_mask(input int width);
    logic [AVM_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < AVM_DATA_W; b++) begin
      if (b < width) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/avm_wait_timer.sv
// -----------------------------------------------------------------------------
// avm_wait_timer
// Counts stalled cycles of one Avalon-MM transfer and flags when the transfer
// has been stalled for TIMEOUT cycles.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   clear   - restart the count (driven whenever no transfer is in progress or
//             the current one is finishing, so each new transfer starts at 0)
//   stall   - strobe is high and waitrequest is high this cycle
//   expired - this cycle is the TIMEOUT-th consecutive stalled cycle; the
//             owner must give up on the transfer at the end of it
// -----------------------------------------------------------------------------
module avm_wait_timer
  import layer_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  // Count holds the number of stalled cycles already seen (0..TIMEOUT-1).
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (stall && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires on the stalled cycle that brings the total to TIMEOUT, so the
  // strobe is held for exactly TIMEOUT stalled cycles before being dropped.
  assign expired = stall && (r_count == LAST);

endmodule

// File: rtl/layer_config_master.sv
// -----------------------------------------------------------------------------
// layer_config_master
// Programs the nInputs register of NUM_NEURONS neuron slaves over Avalon-MM and
// reads each one back to verify it. One start request writes every neuron in
// order (write, read back, compare), then pulses done.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   start                 - 1-cycle request; ignored while busy
//   cfg_ninputs           - neuron i value in [i*VAL_W +: VAL_W], latched at start
//   avm_address           - byte address BASE_ADDR + index*STRIDE during transfers
//   avm_write / avm_read  - mutually exclusive strobes
//   avm_writedata         - neuron value zero-extended to 32 bits
//   avm_readdata          - readback, valid when avm_read & !avm_waitrequest
//   avm_waitrequest       - fabric stall
//   busy                  - high in every state except IDLE
//   done                  - 1-cycle pulse at the end of a run
//   error / err_index     - first failing neuron (mismatch or timeout), held
//                           until the next accepted start
// -----------------------------------------------------------------------------
module layer_config_master
  import layer_ctrl_pkg::*;
#(
  parameter int                    NUM_NEURONS = 4,
  parameter int                    VAL_W       = 3,
  parameter logic [AVM_DATA_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [AVM_DATA_W-1:0] STRIDE      = DEFAULT_STRIDE,
  parameter int                    TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_NEURONS*VAL_W-1:0] cfg_ninputs,
  output logic [AVM_DATA_W-1:0]        avm_address,
  output logic                         avm_write,
  output logic                         avm_read,
  output logic [AVM_DATA_W-1:0]        avm_writedata,
  input  logic [AVM_DATA_W-1:0]        avm_readdata,
  input  logic                         avm_waitrequest,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [ERR_IDX_W-1:0]         err_index
);

  localparam int                    CFG_W      = NUM_NEURONS * VAL_W;
  localparam logic [ERR_IDX_W-1:0]  LAST_IDX   = ERR_IDX_W'(NUM_NEURONS - 1);
  localparam logic [AVM_DATA_W-1:0] FIELD_MASK = field_mask(VAL_W);

  state_t               r_state;
  logic [CFG_W-1:0]     r_cfg;
  logic [ERR_IDX_W-1:0] r_index;
  logic                 r_error;
  logic [ERR_IDX_W-1:0] r_err_index;

  // Readback captured in READ, judged in CHECK.
  logic [VAL_W-1:0]     r_cap_field;
  logic                 r_cap_upper;
  logic                 r_cap_timeout;

  logic [VAL_W-1:0]      w_val;
  logic [AVM_DATA_W-1:0] w_slot_addr;
  logic                  w_in_xfer;
  logic                  w_stall;
  logic                  w_expired;
  logic                  w_xfer_end;
  logic                  w_clear;
  logic                  w_mismatch;
  logic                  w_rd_upper;

  assign w_val       = r_cfg[r_index*VAL_W +: VAL_W];
  assign w_slot_addr = BASE_ADDR + (AVM_DATA_W'(r_index) * STRIDE);

  assign w_in_xfer  = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign w_stall    = w_in_xfer && avm_waitrequest;
  // A transfer ends when the fabric accepts it or when we give up on it.
  assign w_xfer_end = w_in_xfer && (!avm_waitrequest || w_expired);
  // Holding clear outside transfers and on the final cycle of each one means
  // the next WRITE or READ always starts with a zero count.
  assign w_clear    = !w_in_xfer || w_xfer_end;

  // Any readback bit above the field is a slave fault.
  assign w_rd_upper = |(avm_readdata & ~FIELD_MASK);

  // A read that timed out has no trustworthy data and counts as a mismatch.
  assign w_mismatch = r_cap_timeout || r_cap_upper || (r_cap_field != w_val);

  avm_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .stall   (w_stall),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cfg         <= '0;
      r_index       <= '0;
      r_error       <= 1'b0;
      r_err_index   <= '0;
      r_cap_field   <= '0;
      r_cap_upper   <= 1'b0;
      r_cap_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cfg       <= cfg_ninputs;
            r_index     <= '0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_state     <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (!avm_waitrequest) begin
            r_state <= ST_READ;
          end else if (w_expired) begin
            // Give up on the write but still read back, as if it completed.
            if (!r_error) begin
              r_error     <= 1'b1;
              r_err_index <= r_index;
            end
            r_state <= ST_READ;
          end
        end

        ST_READ: begin
          if (!avm_waitrequest) begin
            r_cap_field   <= avm_readdata[VAL_W-1:0];
            r_cap_upper   <= w_rd_upper;
            r_cap_timeout <= 1'b0;
            r_state       <= ST_CHECK;
          end else if (w_expired) begin
            r_cap_field   <= '0;
            r_cap_upper   <= 1'b0;
            r_cap_timeout <= 1'b1;
            r_state       <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          // Only the first failing neuron is recorded; the run always continues.
          if (w_mismatch && !r_error) begin
            r_error     <= 1'b1;
            r_err_index <= r_index;
          end
          if (r_index == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= ST_WRITE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so the strobes can never overlap and
  // everything reads zero while idle.
  assign avm_write     = (r_state == ST_WRITE);
  assign avm_read      = (r_state == ST_READ);
  assign avm_address   = w_in_xfer ? w_slot_addr : '0;
  assign avm_writedata = (r_state == ST_WRITE) ? AVM_DATA_W'(w_val) : '0;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign error         = r_error;
  assign err_index     = r_err_index;

endmodule

// File: doc/layer_config_master.md
LAYER_CONFIG_MASTER -- requirements
Module: layer_config_master

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 4, giving the number of neuron nInputs slaves to program (1..16).
REQ-002 The block SHALL have parameter VAL_W, default 3, giving the nInputs field width in bits (1..32).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of neuron 0's data register (offset 0).
REQ-004 The block SHALL have parameter STRIDE, default 32'h10, giving the byte distance between consecutive neuron slaves.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, giving the maximum waitrequest cycles tolerated per transfer.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle request to program all neurons; ignored while busy.
REQ-009 The block SHALL have port cfg_ninputs, input, NUM_NEURONS*VAL_W bits: neuron i's value in bits [i*VAL_W +: VAL_W], sampled at accepted start.
REQ-010 The block SHALL have port avm_address, output, 32 bits: Avalon-MM byte address.
REQ-011 The block SHALL have ports avm_write and avm_read, output, 1 bit each: Avalon-MM write and read strobes.
REQ-012 The block SHALL have port avm_writedata, output, 32 bits: value zero-extended from VAL_W.
REQ-013 The block SHALL have port avm_readdata, input, 32 bits: read response, valid in the cycle avm_read is high and avm_waitrequest is low.
REQ-014 The block SHALL have port avm_waitrequest, input, 1 bit: fabric stall.
REQ-015 The block SHALL have ports busy (output, 1 bit), done (output, 1-cycle pulse), error (output, 1 bit, sticky until next start) and err_index (output, 4 bits).

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, CHECK, DONE.
- IDLE -> WRITE on start; latch cfg_ninputs; index=0; clear error.
REQ-017 In WRITE the block SHALL hold avm_write=1, avm_address=BASE_ADDR+index*STRIDE, avm_writedata={0,val[index]} stable until a cycle with avm_waitrequest=0, then go to READ.
REQ-018 In READ the block SHALL hold avm_read=1 at the same address until avm_waitrequest=0, capture avm_readdata[VAL_W-1:0] and bits above VAL_W in that cycle, then go to CHECK.
REQ-019 In CHECK the block SHALL flag a mismatch if the captured field differs from val[index] or any upper readdata bit is 1.
- On mismatch with error clear: set error and err_index=index.
- Continue to the next neuron regardless.
REQ-020 From CHECK, if index==NUM_NEURONS-1 the FSM SHALL go to DONE, else increment index and go to WRITE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 avm_write and avm_read SHALL never be high together and SHALL be 0 outside WRITE/READ.
REQ-023 A per-transfer wait counter SHALL reset on entry to WRITE or READ; if it reaches TIMEOUT with waitrequest still high:
- drop the strobe;
- set error with err_index=index if error is clear;
- advance as if the transfer completed (a timed-out read counts as a mismatch).
REQ-024 busy SHALL be 1 in every state except IDLE; start during busy SHALL be ignored with no queuing.
REQ-025 Transaction latency per neuron with zero wait states SHALL be 3 cycles (WRITE, READ, CHECK); a full run SHALL take 3*NUM_NEURONS+1 cycles from start to done.

Reset
REQ-026 Asserting reset in any cycle, including mid-transfer, SHALL force IDLE and clear the latched values, index, wait counter and captured data to 0.
REQ-027 During reset and in the following cycle busy, done, error, err_index, avm_write, avm_read, avm_address and avm_writedata SHALL all be 0.

Structure
REQ-028 A shared package layer_ctrl_pkg SHALL hold the FSM state enum, the default STRIDE/BASE_ADDR constants and the Avalon-MM data width (32).
REQ-029 The wait/timeout counter SHALL be one sub-module, avm_wait_timer, with inputs clear and stall and output expired.

Verification
REQ-030 Zero-wait fabric with 4 PIO models; cfg_ninputs = {3'd7,3'd0,3'd5,3'd2}; start -> writes to 0x00,0x10,0x20,0x30 with data 2,5,0,7; done at cycle 13; error=0.
REQ-031 Slave 2 waitrequest held 3 cycles on write -> avm_write and avm_address=0x20 stable for 4 cycles; no error; done at cycle 16.
REQ-032 Slave 1 returns readdata=0x0000_0008 -> error=1, err_index=1; run completes with done.
REQ-033 Slave 3 waitrequest stuck high -> strobe dropped after 255 cycles; error=1, err_index=3; done pulses.
REQ-034 start pulsed again during busy -> ignored; reset asserted during neuron 2 WRITE -> all outputs 0 next cycle; a fresh start reprograms from neuron 0.
